// File: rtl/nab_axil_regbank.sv
// nab_axil_regbank: parametrised AXI4-Lite register bank (RW control, RO status, SC pulse bits); optional NAB_REGBANK_SNAPSHOT_EN shadows status
module nab_axil_regbank #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          NUM_RW     = 4,
    parameter int          NUM_RO     = 4,
    parameter logic [31:0] RW_RST_VAL = 32'h0,
    parameter logic [31:0] SC_MASK    = 32'h0000_0004
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [32*NUM_RW-1:0]   ctrl_o,
    output logic [31:0]            pulse_o,
    input  logic [32*NUM_RO-1:0]   status_i
);
    localparam int IW = ADDR_WIDTH - 2;

    logic            aw_full, w_full, commit, wr_ok, ar_take, rd_ok;
    logic [IW-1:0]   aw_idx, ar_idx;
    logic [31:0]     w_data, wmask, rd_word;
    logic [3:0]      w_strb;
    logic [31:0]     ctrl_q [NUM_RW];
    logic [31:0]     stat_w [NUM_RO];
    logic            unused_addr_bits;

    assign ar_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign commit           = aw_full & w_full & ~S_AXI_BVALID;
    assign wr_ok            = aw_idx < IW'(NUM_RW);
    assign ar_take          = S_AXI_ARVALID & ~S_AXI_RVALID;
    assign wmask            = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign S_AXI_AWREADY    = ~aw_full;
    assign S_AXI_WREADY     = ~w_full;
    assign S_AXI_ARREADY    = ~S_AXI_RVALID;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar k = 0; k < NUM_RW; k++) begin : g_ctrl
        assign ctrl_o[32*k +: 32] = ctrl_q[k];
    end
    for (genvar k = 0; k < NUM_RO; k++) begin : g_stat
        assign stat_w[k] = status_i[32*k +: 32];
    end

`ifdef NAB_REGBANK_SNAPSHOT_EN
    logic [31:0] shadow [NUM_RO];

    // a read of the first status word freezes all status words for a coherent burst of reads
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_RO; k++) shadow[k] <= '0;
        end else if (ar_take && ar_idx == IW'(NUM_RW)) begin
            for (int k = 0; k < NUM_RO; k++) shadow[k] <= stat_w[k];
        end
    end
`endif

    // AW and W are buffered independently and drained together on commit
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            aw_full <= commit ? 1'b0 : aw_full | S_AXI_AWVALID;
            w_full  <= commit ? 1'b0 : w_full | S_AXI_WVALID;
            if (S_AXI_AWVALID && !aw_full) aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            if (S_AXI_WVALID && !w_full) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    // write response: raised on commit, held until the master accepts it
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
        end else begin
            S_AXI_BVALID <= commit | (S_AXI_BVALID & ~S_AXI_BREADY);
            S_AXI_BRESP  <= commit ? (wr_ok ? 2'b00 : 2'b10) : S_AXI_BRESP;
        end
    end

    // byte-masked control word update; self-clearing bits of word 0 only ever pulse
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= RW_RST_VAL & ~(k == 0 ? SC_MASK : 32'h0);
            pulse_o <= '0;
        end else begin
            pulse_o <= (commit && aw_idx == '0) ? SC_MASK & wmask & w_data : '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (commit && aw_idx == IW'(k))
                    ctrl_q[k] <= ((ctrl_q[k] & ~wmask) | (w_data & wmask)) & ~(k == 0 ? SC_MASK : 32'h0);
            end
        end
    end

    // read decode: control words, then status words, anything beyond is an error
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ar_idx == IW'(k)) begin
                rd_word = ctrl_q[k];
                rd_ok   = 1'b1;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (ar_idx == IW'(NUM_RW + k)) begin
`ifdef NAB_REGBANK_SNAPSHOT_EN
                rd_word = k > 0 ? shadow[k] : stat_w[k];
`else
                rd_word = stat_w[k];
`endif
                rd_ok   = 1'b1;
            end
        end
    end

    // read data captured at the AR handshake and held until RREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else begin
            S_AXI_RVALID <= ar_take | (S_AXI_RVALID & ~S_AXI_RREADY);
            if (ar_take) begin
                S_AXI_RDATA <= rd_word;
                S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_nab_axil_regbank.sv
// tb_nab_axil_regbank: directed plus randomized checks of nab_axil_regbank against a word-level register model
module tb_nab_axil_regbank;
    localparam int          NRW = 4;
    localparam int          NRO = 4;
    localparam logic [31:0] SC  = 32'h0000_0004;
    localparam logic [31:0] RST = 32'h0;
`ifdef NAB_REGBANK_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [8:0]         AWADDR, ARADDR;
    logic               AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic               ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]        WDATA, RDATA, pulse_o;
    logic [3:0]         WSTRB;
    logic [1:0]         BRESP, RRESP;
    logic [32*NRW-1:0]  ctrl_o;
    logic [32*NRO-1:0]  status_i;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_ctrl   [NRW];
    logic [31:0] m_stat   [NRO];
    logic [31:0] m_shadow [NRO];

    always_comb for (int k = 0; k < NRO; k++) status_i[32*k +: 32] = m_stat[k];

    nab_axil_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .ctrl_o(ctrl_o), .pulse_o(pulse_o), .status_i(status_i)
    );

    function automatic logic [127:0] exp_ctrl();
        logic [127:0] r = '0;
        for (int k = 0; k < NRW; k++) r[32*k +: 32] = m_ctrl[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NRW; k++) m_ctrl[k] = RST & ~(k == 0 ? SC : 32'h0);
        for (int k = 0; k < NRO; k++) m_shadow[k] = '0;
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bdelay);
        int n = 0;
        bit aw_d = 0, w_d = 0, aw_hs, w_hs;
        int idx = int'(addr[8:2]);
        logic [31:0] bm = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        logic [1:0]  e_resp = idx < NRW ? 2'b00 : 2'b10;
        logic [31:0] e_pulse = idx == 0 ? SC & bm & data : 32'h0;
        if (idx < NRW) m_ctrl[idx] = ((m_ctrl[idx] & ~bm) | (data & bm)) & ~(idx == 0 ? SC : 32'h0);
        while (!(aw_d && w_d) && n < 40) begin
            @(negedge clk);
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = !aw_d && n >= (lead < 0 ? -lead : 0);
            WVALID  = !w_d && n >= (lead > 0 ? lead : 0);
            aw_hs   = AWVALID && AWREADY;
            w_hs    = WVALID && WREADY;
            @(posedge clk);
            aw_d |= aw_hs;
            w_d  |= w_hs;
            n++;
        end
        chk("wr_handshake", {aw_d, w_d}, 2'b11);
        @(negedge clk);
        AWVALID = 0;
        WVALID  = 0;
        chk("b_not_early", BVALID, 1'b0);
        @(negedge clk);
        chk("b_valid", BVALID, 1'b1);
        chk("b_resp", BRESP, e_resp);
        chk("pulse", pulse_o, e_pulse);
        chk("ctrl", ctrl_o, exp_ctrl());
        repeat (bdelay) begin
            @(negedge clk);
            chk("b_hold", BVALID, 1'b1);
            chk("pulse_one_cycle", pulse_o, 32'h0);
        end
        BREADY = 1;
        @(negedge clk);
        BREADY = 0;
        chk("b_clear", BVALID, 1'b0);
        chk("pulse_clear", pulse_o, 32'h0);
    endtask

    task automatic axi_read(input logic [8:0] addr, input int rdelay);
        int n = 0;
        bit hs = 0;
        int idx = int'(addr[8:2]);
        logic [31:0] e_data = 32'h0;
        logic [1:0]  e_resp = 2'b10;
        while (!hs && n < 40) begin
            @(negedge clk);
            ARADDR  = addr;
            ARVALID = 1;
            hs      = ARREADY;
            @(posedge clk);
            n++;
        end
        if (idx < NRW) begin
            e_data = m_ctrl[idx];
            e_resp = 2'b00;
        end else if (idx < NRW + NRO) begin
            e_data = (SNAP && idx > NRW) ? m_shadow[idx-NRW] : m_stat[idx-NRW];
            e_resp = 2'b00;
            if (SNAP && idx == NRW) for (int k = 0; k < NRO; k++) m_shadow[k] = m_stat[k];
        end
        @(negedge clk);
        ARVALID = 0;
        chk("r_valid", RVALID, 1'b1);
        chk("r_data", RDATA, e_data);
        chk("r_resp", RRESP, e_resp);
        chk("ar_blocked", ARREADY, 1'b0);
        repeat (rdelay) begin
            @(negedge clk);
            chk("r_hold_valid", RVALID, 1'b1);
            chk("r_hold_data", RDATA, e_data);
            chk("r_hold_ar", ARREADY, 1'b0);
        end
        RREADY = 1;
        @(negedge clk);
        RREADY = 0;
        chk("r_clear", RVALID, 1'b0);
        chk("ar_ready_again", ARREADY, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        for (int k = 0; k < NRO; k++) m_stat[k] = $urandom;
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("rst_valid", {BVALID, RVALID}, 2'b00);
        chk("rst_resp", {BRESP, RRESP}, 4'b0000);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_pulse", pulse_o, 32'h0);
        chk("rst_ctrl", ctrl_o, exp_ctrl());
        rst_n = 1;

        for (int a = 1; a < NRW; a++) axi_write(9'(a * 4), 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_write(9'h000, 32'h0000_0004, 4'hF, 0, 0);
        axi_read(9'h000, 0);
        axi_write(9'h010, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_read(9'h040, 0);
        axi_write(9'h004, 32'h0000_AB00, 4'b0010, 3, 4);
        axi_write(9'h008, 32'h5555_5555, 4'h0, -2, 0);
        axi_read(9'h014, 5);

        @(negedge clk);
        AWADDR = 9'h008; AWVALID = 1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1;
        @(negedge clk);
        AWVALID = 0; WVALID = 0;
        m_ctrl[2] = 32'h1234_5678;
        @(negedge clk);
        chk("bb_first_b", BVALID, 1'b1);
        chk("bb_first_ctrl", ctrl_o, exp_ctrl());
        AWADDR = 9'h00C; AWVALID = 1; WDATA = 32'h0BAD_F00D; WVALID = 1;
        @(negedge clk);
        AWVALID = 0; WVALID = 0;
        repeat (4) begin
            chk("bb_stall_ready", {AWREADY, WREADY}, 2'b00);
            chk("bb_stall_b", BVALID, 1'b1);
            chk("bb_stall_ctrl", ctrl_o, exp_ctrl());
            @(negedge clk);
        end
        BREADY = 1;
        @(negedge clk);
        chk("bb_gap_b", BVALID, 1'b0);
        chk("bb_gap_aw", AWREADY, 1'b0);
        m_ctrl[3] = 32'h0BAD_F00D;
        @(negedge clk);
        chk("bb_second_b", BVALID, 1'b1);
        chk("bb_second_ctrl", ctrl_o, exp_ctrl());
        @(negedge clk);
        BREADY = 0;
        chk("bb_done", {BVALID, AWREADY}, 2'b01);

        axi_read(9'h010, 0);
        m_stat[1] = m_stat[1] ^ 32'hFFFF_0000;
        axi_read(9'h014, 0);

        @(negedge clk);
        AWADDR = 9'h004; AWVALID = 1;
        @(negedge clk);
        AWVALID = 0;
        chk("mid_aw_held", AWREADY, 1'b0);
        rst_n = 0;
        model_reset();
        #1;
        chk("mid_rst_aw", AWREADY, 1'b1);
        chk("mid_rst_ctrl", ctrl_o, exp_ctrl());
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_b", BVALID, 1'b0);
            chk("post_rst_ctrl", ctrl_o, exp_ctrl());
            chk("post_rst_aw", AWREADY, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            int idx = $urandom_range(0, 9) == 0 ? 127 : int'($urandom_range(0, 9));
            logic [8:0] addr = {7'(idx), 2'($urandom_range(0, 3))};
            m_stat[$urandom_range(0, NRO - 1)] = $urandom;
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
            else
                axi_read(addr, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
